// File: rtl/picnic_pkg.sv
// Shared Picnic definitions for the challenge-expansion stage:
// default repetition count, digest width and trit encoding.
package picnic_pkg;

    localparam int T  = 219;
    localparam int DW = 256;

    localparam int              CH_W      = 2;
    localparam logic [CH_W-1:0] CH_REJECT = 2'b11;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SCAN,
        DONE
    } ce_state_t;

endpackage

// File: rtl/challenge_expand.sv
// Expands SM3 challenge digests into T ZKB++ trits. It reads each digest two bits
// at a time, MSB first, drops the 2'b11 code and asks for a rehash when a digest runs dry.
module challenge_expand
    import picnic_pkg::*;
#(
    parameter int T  = picnic_pkg::T,
    parameter int DW = picnic_pkg::DW,
    localparam int IW = $clog2(T + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          hash_req,
    output logic          rehash,
    input  logic          hash_valid,
    input  logic [DW-1:0] hash_in,
    output logic          ch_valid,
    input  logic          ch_ready,
    output ch_t           ch_value,
    output logic [IW-1:0] ch_index,
    output logic          done
);

    localparam int NP = DW / 2;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [PW-1:0] LAST_PAIR  = PW'(NP - 1);
    localparam logic [IW-1:0] LAST_COUNT = IW'(T - 1);

    ce_state_t     state;
    logic [DW-1:0] shift_buf;
    logic [PW-1:0] pair_idx;
    logic [IW-1:0] count;
    ch_t           pair;
    logic          pair_ok;
    logic          accept;
    logic          consume;

    // Outputs decode only from registered state, so ch_ready and hash_valid never reach them.
    assign pair     = shift_buf[DW-1 -: CH_W];
    assign pair_ok  = (pair != CH_REJECT);
    assign hash_req = (state == REQ);
    assign done     = (state == DONE);
    assign ch_valid = (state == SCAN) && pair_ok;
    assign ch_value = ch_valid ? pair : '0;
    assign ch_index = count;

    // A rejected pair is consumed without a handshake; a good one waits for ch_ready.
    assign accept  = ch_valid && ch_ready;
    assign consume = (state == SCAN) && (!pair_ok || ch_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rehash    <= 1'b0;
            shift_buf <= '0;
            pair_idx  <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count  <= '0;
                        rehash <= 1'b0;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (hash_valid) begin
                        shift_buf <= hash_in;
                        pair_idx  <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (consume) begin
                        shift_buf <= shift_buf << CH_W;
                        pair_idx  <= pair_idx + 1'b1;
                        if (accept) begin
                            count <= count + 1'b1;
                        end
                        // Finishing wins over running out of pairs; leftovers are discarded.
                        if (accept && count == LAST_COUNT) begin
                            state <= DONE;
                        end else if (pair_idx == LAST_PAIR) begin
                            rehash <= 1'b1;
                            state  <= REQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_value_legal: assert property (@(posedge clk) disable iff (reset)
        ch_valid |-> (ch_value != CH_REJECT));

    a_hold_under_stall: assert property (@(posedge clk) disable iff (reset)
        (ch_valid && !ch_ready) |=> (ch_valid && $stable(ch_value) && $stable(ch_index)));

endmodule

// File: tb/tb_challenge_expand.sv
// Randomized bench for challenge_expand: a queue-based model turns each digest list
// into the expected trit stream, and an upstream driver serves digests on request.
module tb_challenge_expand;

    localparam int TT    = picnic_pkg::T;
    localparam int DW    = picnic_pkg::DW;
    localparam int PAIRS = DW / 2;
    localparam int IW    = $clog2(TT + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          hash_req;
    logic          rehash;
    logic          hash_valid;
    logic [DW-1:0] hash_in;
    logic          ch_valid;
    logic          ch_ready;
    logic [1:0]    ch_value;
    logic [IW-1:0] ch_index;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] digQ[$];
    int            expQ[$];
    int            cumTrits[$];

    challenge_expand #(.T(TT), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .hash_req   (hash_req),
        .rehash     (rehash),
        .hash_valid (hash_valid),
        .hash_in    (hash_in),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_value   (ch_value),
        .ch_index   (ch_index),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [DW-1:0] rand256();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) begin
            r[i*32 +: 32] = $urandom();
        end
        return r;
    endfunction

    // Expected trits: every non-11 pair of every digest in order, cut off at TT.
    // cumTrits[n] is how many trits exist once digests 0..n are exhausted.
    function automatic void buildModel();
        logic [DW-1:0] dg;
        int            v;
        expQ.delete();
        cumTrits.delete();
        for (int d = 0; d < digQ.size(); d++) begin
            dg = digQ[d];
            for (int p = PAIRS - 1; p >= 0; p--) begin
                v = int'(dg[2*p +: 2]);
                if (v != 3 && expQ.size() < TT) begin
                    expQ.push_back(v);
                end
            end
            cumTrits.push_back(expQ.size());
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic applyStimulus(input int readyPct, input int validPct, input int bubbleLat,
                                 input int abortAt, input int midStartAt, input int stallAt,
                                 input bit startAtDone);
        int                  got        = 0;
        int                  nDig       = 0;
        int                  cyc        = 0;
        int                  loadCyc    = -1;
        int                  firstValid = -1;
        int                  lastAcc    = -1;
        bit                  finished   = 1'b0;
        bit                  aborted    = 1'b0;
        logic                pv         = 1'b0;
        logic                pready     = 1'b1;
        logic [1:0]          pval       = '0;
        logic [IW-1:0]       pidx       = '0;

        buildModel();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("req_after_start", hash_req, 1);
        checkOutput("rehash_first", rehash, 0);

        while (!finished && !aborted && cyc < 4000) begin
            if (pv && !pready) begin
                checkOutput("hold_valid", ch_valid, 1);
                checkOutput("hold_value", ch_value, pval);
                checkOutput("hold_index", ch_index, pidx);
            end
            if (ch_valid && firstValid < 0) begin
                firstValid = cyc;
            end

            if (done) begin
                finished = 1'b1;
                checkOutput("done_after_last", cyc, lastAcc + 1);
                checkOutput("done_quiet", {hash_req, ch_valid}, 0);
                start      = startAtDone;
                ch_ready   = 1'b1;
                hash_valid = 1'b0;
            end else if (abortAt >= 0 && ch_valid && ch_index == abortAt) begin
                aborted    = 1'b1;
                reset      = 1'b1;
                start      = 1'b0;
                ch_ready   = 1'b1;
                hash_valid = 1'b1;
                hash_in    = rand256();
            end else begin
                ch_ready = !(cyc >= stallAt && cyc < stallAt + 5) &&
                           ($urandom_range(0, 99) < readyPct);
                if (ch_valid && ch_ready) begin
                    if (got < expQ.size()) begin
                        checkOutput("trit_value", ch_value, expQ[got]);
                    end else begin
                        checkOutput("extra_trit", got, expQ.size());
                    end
                    checkOutput("trit_index", ch_index, got);
                    lastAcc = cyc;
                    got++;
                end
                if (hash_req) begin
                    hash_valid = (nDig < digQ.size()) && ($urandom_range(0, 99) < validPct);
                    hash_in    = hash_valid ? digQ[nDig] : rand256();
                    if (hash_valid) begin
                        checkOutput("rehash_flag", rehash, (nDig > 0));
                        if (nDig > 0) begin
                            checkOutput("trits_before_rehash", got, cumTrits[nDig-1]);
                        end else begin
                            loadCyc = cyc;
                        end
                        nDig++;
                    end
                end else begin
                    hash_valid = 1'($urandom_range(0, 1));
                    hash_in    = rand256();
                end
                start = (cyc == midStartAt);
            end

            pv     = ch_valid;
            pval   = ch_value;
            pidx   = ch_index;
            pready = ch_ready;
            @(negedge clk);
            cyc++;
        end

        if (aborted) begin
            checkOutput("abort_hash_req", hash_req, 0);
            checkOutput("abort_rehash", rehash, 0);
            checkOutput("abort_ch_valid", ch_valid, 0);
            checkOutput("abort_ch_value", ch_value, 0);
            checkOutput("abort_ch_index", ch_index, 0);
            checkOutput("abort_done", done, 0);
            reset      = 1'b0;
            hash_valid = 1'b0;
        end else if (!finished) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            start = 1'b0;
            checkOutput("idle_after_done", {hash_req, ch_valid, done}, 0);
            checkOutput("trit_count", got, TT);
            if (bubbleLat >= 0) begin
                checkOutput("first_valid_lat", firstValid - loadCyc, bubbleLat);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        hash_valid = 1'b0;
        hash_in    = '0;
        ch_ready   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_hash_req", hash_req, 0);
        checkOutput("reset_rehash", rehash, 0);
        checkOutput("reset_ch_valid", ch_valid, 0);
        checkOutput("reset_ch_value", ch_value, 0);
        checkOutput("reset_ch_index", ch_index, 0);
        checkOutput("reset_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] all-zero digests");
        digQ.delete();
        repeat (2) digQ.push_back('0);
        applyStimulus(100, 100, 1, -1, -1, -1, 1'b0);

        $display("[TB] repeated 0xE4 digests, start during done");
        digQ.delete();
        repeat (3) digQ.push_back({(DW/8){8'hE4}});
        applyStimulus(100, 100, 2, -1, -1, -1, 1'b1);

        $display("[TB] all-ones digest then all-zero digests");
        digQ.delete();
        digQ.push_back('1);
        repeat (2) digQ.push_back('0);
        applyStimulus(100, 100, -1, -1, -1, -1, 1'b0);

        $display("[TB] random digests, 5-cycle stall, start mid-scan");
        digQ.delete();
        repeat (6) digQ.push_back(rand256());
        applyStimulus(100, 60, -1, -1, 37, 20, 1'b0);

        $display("[TB] random digests, reset at index 50");
        digQ.delete();
        repeat (6) digQ.push_back(rand256());
        applyStimulus(70, 50, -1, 50, -1, -1, 1'b0);

        for (int r = 0; r < 3; r++) begin
            $display("[TB] random run %0d", r);
            digQ.delete();
            repeat (6) digQ.push_back(rand256());
            applyStimulus(50 + 15 * r, 40 + 20 * r, -1, -1, -1, 10 + r, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/challenge_expand.md
# challenge_expand

Converts 256-bit SM3 digests from the challenge-hash stage into the per-round ZKB++ challenge trits e_i ∈ {0,1,2} for Picnic signing and verification. It sits directly downstream of the C* challenge hash.
- Reads each digest two bits at a time, MSB first, and rejects the code 2'b11.
- When a digest runs out before T trits are produced, it requests a rehash (H of the previous digest) from the hash stage.
- Trits stream out on a valid/ready interface to the view-opening logic.

## Interface
- T, default 219: number of parallel repetitions, i.e. trits to produce (1..1023).
- DW, default 256: digest width in bits, even; pairs per digest = DW/2.
- clk  in  1: rising-edge clock.
- reset  in  1: synchronous, active-high; one clock domain only.
- start  in  1: single-cycle pulse that begins an expansion; ignored unless IDLE.
- hash_req  out  1: request for a digest from the hash stage.
- rehash  out  1: qualifies hash_req. 0 = first digest of this expansion; 1 = hash the previous digest again.
- hash_valid  in  1: digest available.
- hash_in  in  DW: digest; sampled only on hash_req && hash_valid.
- ch_valid  out  1: trit available.
- ch_ready  in  1: consumer accepts the trit.
- ch_value  out  2: trit value (0, 1 or 2).
- ch_index  out  clog2(T+1): round index of the current trit, 0..T-1.
- done  out  1: one-cycle pulse after trit T-1 is accepted.

## Operation
- State IDLE. On start: clear count and rehash, go to REQ.
- State REQ. Drive hash_req=1.
  - On hash_valid: latch hash_in into shift buffer buf, clear pair_idx, go to SCAN.
- State SCAN. Current pair p = buf[DW-1:DW-2].
  - p==2'b11: drop it. Shift buf left by 2, increment pair_idx; takes 1 cycle and emits nothing.
  - p!=2'b11: drive ch_valid=1, ch_value=p, ch_index=count. On ch_ready: shift, increment pair_idx, increment count.
  - If ch_ready is low: hold buf, pair_idx and count; ch_value is stable.
- Exit from SCAN, evaluated on the consuming cycle. Priority is top to bottom:
  - count reaches T: go to DONE. Any leftover pairs are discarded.
  - Last pair consumed (pair_idx==DW/2-1): set rehash=1, go to REQ.
- State DONE. done=1 for exactly one cycle, then go to IDLE.
- Reset values:
  - State = IDLE.
  - hash_req, rehash, ch_valid, done, ch_value, ch_index = 0.
  - buf, count, pair_idx = 0.
- reset mid-operation aborts at once. hash_req drops the next cycle; any pending upstream digest is never sampled.

## Timing
- start → hash_req=1 on the following cycle.
- hash_req and hash_valid high in the same cycle (cycle k): buf loaded; ch_valid may be high at k+1.
- In SCAN, each cycle consumes at most one pair. Throughput is 1 trit/cycle with ch_ready held high.
- A rejected pair costs one bubble cycle with ch_valid=0.
- Rehash turnaround: the cycle after the last pair, hash_req=1 with rehash=1. Latency then depends on the upstream stage.
- The last trit accepted at cycle k gives done=1 at k+1 and IDLE at k+2. A start at k+2 is honoured.
- Outputs are registered or decoded from state only.
  - No combinational path from ch_ready to ch_valid or ch_value.
  - No combinational path from hash_valid to hash_req.

## Structure
- Shared picnic_pkg holds:
  - Constants: T, DW, CH_W=2, CH_REJECT=2'b11.
  - typedef ch_t (2-bit trit).
  - The challenge_expand state enum {IDLE, REQ, SCAN, DONE}.
- Single module, no sub-module.
  - The buffer/pair counter could be factored out, but it is too small to justify a separate module.
- The SM3 core is not instantiated here. The upstream hash stage owns the sm3_CF instance and serves rehash requests.

## Test plan
- All-zero digest, T=219:
  - 128 trits of 0, indices 0..127.
  - Then hash_req with rehash=1.
  - Second all-zero digest gives indices 128..218, then one done pulse.
- Digest of repeated 0xE4 (pairs 11,10,01,00), T=3:
  - Outputs 2, 1, 0 at indices 0..2.
  - One bubble cycle before the first trit; done after index 2.
- All-ones digest followed by all-zero digest, T=4:
  - Zero trits for 128 cycles, then rehash request.
  - Then trits 0,0,0,0 and done.
- Backpressure: ch_ready low for 5 cycles mid-stream.
  - ch_valid, ch_value and ch_index held constant.
  - No pair skipped or duplicated.
- reset asserted in SCAN at count=50:
  - Next cycle: IDLE, all outputs 0.
  - A subsequent start restarts at index 0 with rehash=0.
- start pulsed while in SCAN: ignored. A start in the same cycle as done is ignored; a start one cycle later is accepted.
